// File: rtl/mult_sched_pkg.sv
// -----------------------------------------------------------------------------
// mult_sched_pkg
// Shared definitions for the multiplier scheduler:
//   - sched_state_e : scheduler FSM states
//   - DEF_WIDTH     : default operand width
//   - DEF_NUM_REQ   : default number of requesters
//   - id_w()        : width of an index into n items (at least 1 bit)
// -----------------------------------------------------------------------------
package mult_sched_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    // A single-item index still needs one physical bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotate-priority arbiter. Picks the first asserted request
// strictly after last_grant, wrapping modulo NUM_REQ.
// Ports:
//   req_valid  in  NUM_REQ  request vector
//   last_grant in  ID_W     index granted most recently
//   gnt_onehot out NUM_REQ  one-hot grant (all zero when nothing is valid)
//   gnt_id     out ID_W     index of the grant
//   any        out 1        some request is valid
// -----------------------------------------------------------------------------
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_w(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        found      = 1'b0;
        gnt_id     = '0;
        gnt_onehot = '0;
        idx        = '0;
        // Offset 1 first, offset NUM_REQ (last_grant itself) last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        gnt_onehot[gnt_id] = found;
        any                = found;
    end

endmodule

// File: rtl/mult_scheduler.sv
// -----------------------------------------------------------------------------
// mult_scheduler
// Shares one sequential multiplier among NUM_REQ requesters. One job at a
// time: accept (round-robin) -> start multiplier -> wait for done under a
// watchdog -> present tagged response until accepted.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready          per-requester handshake (ready is one-hot)
//   req_multiplicand/multiplier  packed operands, slice [i*WIDTH +: WIDTH]
//   mul_start                    one-cycle start pulse to the multiplier
//   mul_multiplicand/multiplier  latched operands for the multiplier
//   mul_done/mul_product         multiplier completion and result
//   resp_valid/resp_ready        response handshake
//   resp_id/resp_product/resp_error  response payload
//   busy                         any state other than IDLE
// -----------------------------------------------------------------------------
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_multiplicand,
    input  logic [NUM_REQ*WIDTH-1:0]   req_multiplier,
    output logic                       mul_start,
    output logic [WIDTH-1:0]           mul_multiplicand,
    output logic [WIDTH-1:0]           mul_multiplier,
    input  logic                       mul_done,
    input  logic [2*WIDTH-1:0]         mul_product,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [id_w(NUM_REQ)-1:0]   resp_id,
    output logic [2*WIDTH-1:0]         resp_product,
    output logic                       resp_error,
    output logic                       busy
);

    localparam int ID_W  = id_w(NUM_REQ);
    localparam int CNT_W = id_w(TIMEOUT);

    sched_state_e        state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [2*WIDTH-1:0]  product_q, product_d;
    logic                error_q, error_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  req_ready_c;
    logic [NUM_REQ-1:0]  arb_onehot;
    logic [ID_W-1:0]     arb_id;
    logic                arb_any;

    logic [WIDTH-1:0]    req_mc_arr [NUM_REQ];
    logic [WIDTH-1:0]    req_mp_arr [NUM_REQ];
    logic [WIDTH-1:0]    win_mc;
    logic [WIDTH-1:0]    win_mp;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_mc_arr[i] = req_multiplicand[i*WIDTH +: WIDTH];
            req_mp_arr[i] = req_multiplier[i*WIDTH +: WIDTH];
        end
    end

    assign win_mc = req_mc_arr[arb_id];
    assign win_mp = req_mp_arr[arb_id];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .gnt_onehot (arb_onehot),
        .gnt_id     (arb_id),
        .any        (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        product_d    = product_q;
        error_d      = error_q;
        cnt_d        = cnt_q;
        req_ready_c  = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready_c = arb_onehot;
                    id_d        = arb_id;
                    mcand_d     = win_mc;
                    mplier_d    = win_mp;
                    // A zero operand makes the product trivially zero, so the
                    // multiplier is never started for it.
                    if ((win_mc == '0) || (win_mp == '0)) begin
                        product_d = '0;
                        error_d   = 1'b0;
                        state_d   = RESP;
                    end else begin
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done is tested first so it wins over a same-cycle timeout.
                if (mul_done) begin
                    product_d = mul_product;
                    error_d   = 1'b0;
                    state_d   = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    product_d = '0;
                    error_d   = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    last_grant_d = id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            product_q    <= '0;
            error_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            product_q    <= product_d;
            error_q      <= error_d;
            cnt_q        <= cnt_d;
        end
    end

    // The state register sits in IDLE during reset, so the combinational
    // accept path is also gated by the pin to keep req_ready low in reset.
    assign req_ready        = reset ? req_ready_c : '0;
    assign mul_start        = (state_q == ISSUE);
    assign mul_multiplicand = mcand_q;
    assign mul_multiplier   = mplier_q;
    assign resp_valid       = (state_q == RESP);
    assign resp_id          = id_q;
    assign resp_product     = product_q;
    assign resp_error       = error_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_mult_scheduler.sv
module tb_mult_scheduler;

    localparam int NR  = 4;
    localparam int W   = 16;
    localparam int T   = 16;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_multiplicand;
    logic [NR*W-1:0]   req_multiplier;
    logic              mul_start;
    logic [W-1:0]      mul_multiplicand;
    logic [W-1:0]      mul_multiplier;
    logic              mul_done;
    logic [2*W-1:0]    mul_product;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [2*W-1:0]    resp_product;
    logic              resp_error;
    logic              busy;

    logic [W-1:0] op_a [NR];
    logic [W-1:0] op_b [NR];

    always #5 clk = ~clk;

    always_comb begin
        req_multiplicand = '0;
        req_multiplier   = '0;
        for (int i = 0; i < NR; i++) begin
            req_multiplicand[i*W +: W] = op_a[i];
            req_multiplier[i*W +: W]   = op_b[i];
        end
    end

    mult_scheduler #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(T)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_multiplicand (req_multiplicand),
        .req_multiplier   (req_multiplier),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_done         (mul_done),
        .mul_product      (mul_product),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_id          (resp_id),
        .resp_product     (resp_product),
        .resp_error       (resp_error),
        .busy             (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int          id;
        logic [31:0] prod;
        logic        err;
        int          cyc;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t        exp_q[$];
    int          dly_q[$];
    int          grant_log[$];
    int          forced_delay = 0;
    int          last_g = NR - 1;
    bit          in_flight = 0;
    int          start_cyc = -1;
    int          n_start = 0;
    bit          prev_rv = 0;
    logic [34:0] prev_pay = '0;
    logic [31:0] last_resp_prod = '0;
    logic        last_resp_err = 1'b0;
    int          last_resp_id = -1;

    function automatic int pick_delay();
        if ($urandom_range(0, 3) == 0) return T - 1 + int'($urandom_range(0, 3));
        return int'($urandom_range(1, 8));
    endfunction

    // Monitor: predicts each accepted job and checks the DUT against it.
    always @(negedge clk) begin
        int   w;
        int   j;
        int   d;
        exp_t e;
        if (!reset) begin
            exp_q.delete();
            dly_q.delete();
            in_flight = 0;
            last_g    = NR - 1;
            start_cyc = -1;
            prev_rv   = 0;
        end else begin
            chk("busy", busy, in_flight);
            if (req_ready != '0) begin
                chk("ready_onehot", $onehot(req_ready), 1);
                chk("ready_while_busy", in_flight, 0);
                w = -1;
                for (int k = 1; k <= NR; k++) begin
                    j = (last_g + k) % NR;
                    if (w < 0 && req_valid[j]) w = j;
                end
                chk("grant", req_ready, (w < 0) ? 0 : (1 << w));
                if (w >= 0) begin
                    grant_log.push_back(w);
                    e.id = w;
                    e.a  = op_a[w];
                    e.b  = op_b[w];
                    if (e.a == 0 || e.b == 0) begin
                        e.prod = 0;
                        e.err  = 0;
                        e.cyc  = cyc + 1;
                    end else begin
                        d = (forced_delay > 0) ? forced_delay : pick_delay();
                        dly_q.push_back(d);
                        start_cyc = cyc + 1;
                        if (d <= T) begin
                            e.prod = 32'(e.a) * 32'(e.b);
                            e.err  = 0;
                            e.cyc  = cyc + 1 + d + 1;
                        end else begin
                            e.prod = 0;
                            e.err  = 1;
                            e.cyc  = cyc + 1 + T + 1;
                        end
                    end
                    exp_q.push_back(e);
                    in_flight = 1;
                end
            end
            chk("mul_start", mul_start, (cyc == start_cyc));
            if (mul_start) begin
                n_start++;
                if (exp_q.size() > 0) begin
                    chk("mul_a", mul_multiplicand, exp_q[0].a);
                    chk("mul_b", mul_multiplier, exp_q[0].b);
                end
            end
            if (resp_valid) begin
                if (!prev_rv) begin
                    if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
                    else chk("resp_latency", cyc, exp_q[0].cyc);
                end else begin
                    chk("resp_hold", {resp_id, resp_product, resp_error}, prev_pay);
                end
                if (resp_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("resp_id", resp_id, e.id);
                    chk("resp_product", resp_product, e.prod);
                    chk("resp_error", resp_error, e.err);
                    last_g         = e.id;
                    in_flight      = 0;
                    last_resp_prod = resp_product;
                    last_resp_err  = resp_error;
                    last_resp_id   = int'(resp_id);
                end
            end
            prev_rv  = resp_valid;
            prev_pay = {resp_id, resp_product, resp_error};
        end
    end

    // Multiplier model: answers each start after the delay chosen for the job.
    initial begin
        int          d;
        logic [15:0] a;
        logic [15:0] b;
        mul_done    = 1'b0;
        mul_product = '0;
        forever begin
            @(negedge clk);
            if (reset && mul_start) begin
                d = (dly_q.size() > 0) ? dly_q.pop_front() : 1000;
                a = mul_multiplicand;
                b = mul_multiplier;
                if (d <= T + 2) begin
                    repeat (d) @(posedge clk);
                    #1;
                    mul_done    = 1'b1;
                    mul_product = 32'(a) * 32'(b);
                    @(posedge clk);
                    #1;
                    mul_done    = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int mode = 0;  // 0 directed, 1 all-valid, 2 random

    function automatic logic [15:0] rand_op();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 16'h0000;
        if (r == 1) return 16'hFFFF;
        return 16'($urandom);
    endfunction

    function automatic logic [15:0] nz_op();
        return 16'($urandom_range(1, 16'hFFFF));
    endfunction

    task automatic step();
        logic [NR-1:0] rr;
        @(negedge clk);
        rr = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (rr[i]) begin
                if (mode == 1) begin
                    req_valid[i] = 1'b1;
                    op_a[i] = nz_op();
                    op_b[i] = nz_op();
                end else if (mode == 2) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    op_a[i] = rand_op();
                    op_b[i] = rand_op();
                end else begin
                    req_valid[i] = 1'b0;
                end
            end else if (mode == 2) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    op_a[i] = rand_op();
                    op_b[i] = rand_op();
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        if (mode == 2) resp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        step();
        while ((in_flight || exp_q.size() != 0 || req_valid != '0) && k < 2000) begin
            step();
            k++;
        end
        if (k >= 2000) chk(nm, 0, 1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_req_ready"}, req_ready, 0);
        chk({nm, "_mul_start"}, mul_start, 0);
        chk({nm, "_mul_ops"}, {mul_multiplicand, mul_multiplier}, 0);
        chk({nm, "_resp_valid"}, resp_valid, 0);
        chk({nm, "_resp_payload"}, {resp_id, resp_product, resp_error}, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    initial begin
        int g0;
        int s0;
        int k;
        int fair_exp[5];
        fair_exp = '{0, 1, 2, 3, 0};

        reset      = 1'b0;
        resp_ready = 1'b1;
        req_valid  = '1;
        for (int i = 0; i < NR; i++) begin
            op_a[i] = nz_op();
            op_b[i] = nz_op();
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");

        // Fairness: everyone valid continuously from reset release.
        mode         = 1;
        forced_delay = 3;
        g0           = grant_log.size();
        @(posedge clk);
        #1;
        reset = 1'b1;
        k = 0;
        while (grant_log.size() < g0 + 5 && k < 500) begin
            step();
            k++;
        end
        if (grant_log.size() < g0 + 5) chk("fair_timeout", 0, 1);
        else for (int i = 0; i < 5; i++) chk("fair_order", grant_log[g0 + i], fair_exp[i]);
        mode      = 0;
        req_valid = '0;
        drain("drain_fair");

        // Single job: requester 2, 3 x 5.
        s0           = n_start;
        forced_delay = 4;
        op_a[2]      = 16'h0003;
        op_b[2]      = 16'h0005;
        req_valid[2] = 1'b1;
        drain("drain_single");
        chk("single_starts", n_start - s0, 1);
        chk("single_id", last_resp_id, 2);
        chk("single_prod", last_resp_prod, 32'h0000000F);
        chk("single_err", last_resp_err, 0);

        // Zero bypass: requester 1, 0 x FFFF.
        s0           = n_start;
        op_a[1]      = 16'h0000;
        op_b[1]      = 16'hFFFF;
        req_valid[1] = 1'b1;
        drain("drain_zero");
        chk("zero_starts", n_start - s0, 0);
        chk("zero_prod", last_resp_prod, 0);
        chk("zero_id", last_resp_id, 1);

        // Timeout: done arrives one cycle too late (lands while in RESP).
        forced_delay = T + 1;
        op_a[3]      = 16'h0007;
        op_b[3]      = 16'h0009;
        req_valid[3] = 1'b1;
        drain("drain_timeout");
        chk("timeout_err", last_resp_err, 1);
        chk("timeout_prod", last_resp_prod, 0);

        // Done on the very last watchdog cycle still wins.
        forced_delay = T;
        op_a[0]      = 16'h0100;
        op_b[0]      = 16'h0010;
        req_valid[0] = 1'b1;
        drain("drain_edge");
        chk("edge_err", last_resp_err, 0);
        chk("edge_prod", last_resp_prod, 32'h00001000);

        // Backpressure: response held for 10 cycles with another request pending.
        forced_delay = 2;
        resp_ready   = 1'b0;
        op_a[1]      = 16'h1234;
        op_b[1]      = 16'h0002;
        op_a[2]      = 16'h0011;
        op_b[2]      = 16'h0003;
        req_valid[1] = 1'b1;
        req_valid[2] = 1'b1;
        k = 0;
        while (!resp_valid && k < 100) begin
            step();
            k++;
        end
        repeat (10) step();
        chk("bp_resp_held", resp_valid, 1);
        chk("bp_req2_pending", req_valid[2], 1);
        resp_ready = 1'b1;
        drain("drain_bp");

        // Randomized traffic.
        mode         = 2;
        forced_delay = 0;
        repeat (1500) step();
        mode       = 0;
        req_valid  = '0;
        resp_ready = 1'b1;
        drain("drain_random");

        // Reset while waiting on the multiplier; its done arrives afterwards.
        forced_delay = 10;
        s0           = n_start;
        op_a[2]      = 16'h0011;
        op_b[2]      = 16'h0022;
        req_valid[2] = 1'b1;
        k = 0;
        while (n_start == s0 && k < 100) begin
            step();
            k++;
        end
        repeat (3) step();
        #2;
        reset     = 1'b0;
        req_valid = '0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (12) step();
        chk("midrst_idle", {resp_valid, busy}, 0);

        forced_delay = 2;
        g0           = grant_log.size();
        req_valid    = '1;
        for (int i = 0; i < NR; i++) begin
            op_a[i] = nz_op();
            op_b[i] = nz_op();
        end
        k = 0;
        while (grant_log.size() == g0 && k < 100) begin
            step();
            k++;
        end
        req_valid = '0;
        if (grant_log.size() == g0) chk("midrst_no_grant", 0, 1);
        else chk("midrst_first_grant", grant_log[g0], 0);
        drain("drain_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Round-robin scheduler that shares one sequential shift-add multiplier (Datapath + Controller pair) among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes, issues one `mul_start` pulse per job, and waits for `mul_done` under a watchdog. It then returns the product on a single tagged response channel. It sits between the client logic and the multiplier, and is the only block that drives the multiplier's start and operands.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 16: operand width; the product is `2*WIDTH`.
- `TIMEOUT`, default 64: maximum cycles the block waits in WAIT for `mul_done`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; the block is in reset while the pin is 0.
- `req_valid`  in  `NUM_REQ`  per-requester job valid.
- `req_ready`  out  `NUM_REQ`  one-hot accept pulse; at most one bit is high per cycle.
- `req_multiplicand`  in  `NUM_REQ*WIDTH`  packed; requester i uses slice [i*WIDTH +: WIDTH].
- `req_multiplier`  in  `NUM_REQ*WIDTH`  packed, same slicing.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_multiplicand`, `mul_multiplier`  out  `WIDTH` each  latched operands, held stable from ISSUE through WAIT.
- `mul_done`  in  1  multiplier completion pulse.
- `mul_product`  in  `2*WIDTH`  product; valid in the cycle `mul_done` is high.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response accept.
- `resp_id`  out  `$clog2(NUM_REQ)`  index of the requester that owns the response.
- `resp_product`  out  `2*WIDTH`  result.
- `resp_error`  out  1  set when the job hit the watchdog timeout.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is high, the arbiter picks the first valid index strictly after `last_grant`, wrapping modulo `NUM_REQ`.
  - The block pulses `req_ready[winner]` for that cycle and latches the operands and id.
  - If either operand is zero, the block loads product 0, clears error, and goes to RESP. This zero bypass skips the multiplier.
  - Otherwise it goes to ISSUE.
- ISSUE: `mul_start`=1 for exactly one cycle, the watchdog counter is cleared, then WAIT.
- WAIT:
  - On `mul_done`: latch `mul_product`, clear error, go to RESP.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT-1` without `mul_done`, the block loads product 0, sets error, and goes to RESP.
  - If `mul_done` and the timeout occur in the same cycle, `mul_done` wins.
- RESP:
  - `resp_valid`=1, with `resp_id`, `resp_product` and `resp_error` held stable until `resp_ready`.
  - On the handshake, `last_grant` is updated to the winner id and the FSM returns to IDLE.
- `mul_done` outside WAIT is ignored.
- `req_valid` deasserting in a cycle where it is not granted is legal and has no effect.
- Reset values:
  - state IDLE; `last_grant` = `NUM_REQ-1`, so requester 0 wins first.
  - All outputs 0, including `req_ready`, `mul_start`, `resp_*` and `busy`.
- Reset asserted mid-job abandons the job immediately. The multiplier is not re-signalled, and any later stray `mul_done` is ignored.

## Timing
- Request accept (IDLE, `req_ready` high) to `mul_start`: 1 cycle.
- `mul_done` to `resp_valid`: 1 cycle.
- Zero-bypass accept to `resp_valid`: 1 cycle.
- The minimum gap from the `resp_ready` handshake to the next `req_ready` pulse is 1 cycle, because IDLE is re-entered on the next edge.
- Only one job is in flight at a time; no request is accepted outside IDLE.
- With all requesters continuously valid, grants rotate 0,1,2,…,`NUM_REQ-1`,0. No requester waits more than `NUM_REQ-1` jobs.

## Structure
- Package `mult_sched_pkg`: the state enum `sched_state_e` {IDLE, ISSUE, WAIT, RESP}, the default `WIDTH`/`NUM_REQ` constants, and an id-width helper.
- Sub-module `rr_arbiter`: combinational rotate-priority pick from `req_valid` and `last_grant`. Outputs are `gnt_onehot`, `gnt_id` and `any`.
- The top level holds the FSM, the operand and result registers, and the watchdog counter.

## Test plan
- Single job: reset released, requester 2 sends 0x0003 × 0x0005 → one `mul_start` one cycle after `req_ready[2]`; after `mul_done`, `resp_valid` with id 2, product 0x0000000F, error 0.
- Fairness: all four requesters continuously valid → grant order 0,1,2,3,0; no bit of `req_ready` is ever high twice before every other valid requester has been served.
- Zero bypass: requester 1 sends 0x0000 × 0xFFFF → no `mul_start`; `resp_valid` 1 cycle after accept with product 0.
- Timeout: the multiplier model never asserts `mul_done` → after `TIMEOUT` cycles, `resp_valid` with error 1 and product 0; a late `mul_done` is ignored.
- Backpressure: `resp_ready` held low for 10 cycles → outputs stable throughout; no new `req_ready` until the handshake completes.
- Reset mid-WAIT: pull `reset` low → all outputs 0 immediately; after release, requester 0 is granted first.
